// File: rtl/ps2_kbd_rx_if.sv
// Key-event stream from the PS/2 receiver to the character/VGA logic.
// Handshake: the producer raises ev_valid while a head event is presented and
// keeps ev_code/ev_brk/ev_ext stable until it is taken; an event is transferred
// on the clock edge where ev_valid & ev_ready are both 1; ev_ready may be driven
// freely by the consumer and is never required to wait for ev_valid.
interface ps2_kbd_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_brk;
  logic       ev_ext;

  modport master (output ev_valid, ev_code, ev_brk, ev_ext, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_brk, ev_ext, output ev_ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame deserialiser with
// idle timeout, E0/F0 prefix folding and a first-word-fall-through event FIFO.
// Optional feature macro: PS2_PARITY_CHK_EN (odd parity enforced when defined).
// FIFO_AW must be at least 1.
module ps2_kbd_rx #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter bit DECODE      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_kbd_rx_if.master       ev,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic               frm_err
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]         clk_sync_q, dat_sync_q;
  logic               clk_prev_q;
  logic               fall;
  logic [9:0]         shift_q, shift_d;
  logic [10:0]        frame;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               byte_vld_q, byte_vld_d;
  logic [7:0]         byte_q, byte_d;
  logic               frm_err_q, frm_err_d;
  logic               frame_ok, tmo;
  logic               ext_q, ext_d, brk_q, brk_d;
  logic               push;
  logic [9:0]         push_data;
  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full, pop, wr_en, drop;
  logic               ovf_q;

  // Two-stage synchronisers on both pins plus the previous synced clock level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall  = clk_prev_q & ~clk_sync_q[1];
  // Bits arrive LSB first; the current bit completes the frame on the 11th edge.
  assign frame = {dat_sync_q[1], shift_q};

  // Deserialiser: shift on falling edges, judge the frame on the 11th, abort on idle.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_d      = tmr_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    frm_err_d  = 1'b0;
    frame_ok   = 1'b0;
    tmo        = 1'b0;
    if (fall) begin
      shift_d = frame[10:1];
      tmr_d   = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
`ifdef PS2_PARITY_CHK_EN
        frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);
`else
        frame_ok  = ~frame[0] & frame[10];
`endif
        byte_vld_d = frame_ok;
        byte_d     = frame[8:1];
        frm_err_d  = ~frame_ok;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo       = 1'b1;
        bit_cnt_d = '0;
        tmr_d     = '0;
        shift_d   = '0;
        frm_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end else begin
      tmr_d = '0;
    end
  end

  // Deserialiser state and the registered received byte / error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_q      <= tmr_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Prefix folding: E0/F0 only arm flags; any other byte becomes an event.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, byte_q};
    if (tmo) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (DECODE && byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (DECODE && byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Prefix flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  assign full  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
  assign pop   = ev.ev_valid & ev.ev_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Occupancy follows the accepted write and the pop of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      cnt_q <= cnt_d;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Event storage; contents are only ever read behind a valid write.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign ev.ev_valid = (cnt_q != '0);
  assign ev.ev_code  = ev.ev_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign ev.ev_brk   = ev.ev_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
  assign ev.ev_ext   = ev.ev_valid ? mem_q[rd_ptr_q][9]   : 1'b0;
  assign fifo_cnt    = cnt_q;
  assign ovf         = ovf_q;
  assign frm_err     = frm_err_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: a decoding instance and a raw-byte instance listen to
// the same PS/2 lines; expectations are queued when frames are issued and
// compared by independent monitors when events leave each FIFO.
module tb_ps2_kbd_rx;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 5;
`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ps2_clk, ps2_data;
  logic          ovf_clr;
  logic [AW:0]   fifo_cnt, fifo_cnt_r;
  logic          ovf, ovf_r, frm_err, frm_err_r;
  int            checks = 0;
  int            failures = 0;
  logic [9:0]    exp_q[$];
  logic [9:0]    raw_q[$];
  int            frm_exp = 0, frm_seen = 0, frm_seen_r = 0;
  bit            m_ext = 0, m_brk = 0, m_ovf = 0;
  int            ready_mode = 1;
  bit            hold_pend = 0;
  logic [9:0]    hold_v;

  ps2_kbd_rx_if ev_if();
  ps2_kbd_rx_if raw_if();

  ps2_kbd_rx #(.FIFO_AW(AW), .TIMEOUT_CYC(TMO), .DECODE(1'b1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev(ev_if),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr), .frm_err(frm_err));

  ps2_kbd_rx #(.FIFO_AW(AW), .TIMEOUT_CYC(TMO), .DECODE(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev(raw_if),
    .fifo_cnt(fifo_cnt_r), .ovf(ovf_r), .ovf_clr(ovf_clr), .frm_err(frm_err_r));

  assign raw_if.ev_ready = 1'b1;

  // Clock and consumer-ready driver.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      ev_if.ev_ready = 1'b0;
    else if (ready_mode == 1) ev_if.ev_ready = 1'b1;
    else                      ev_if.ev_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for the decoding instance: event order, content and hold behaviour.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold", {ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, {1'b1, hold_v});
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=%0h expected=none",
                   {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code});
        end else begin
          check("event", {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, exp_q.pop_front());
        end
      end
      hold_pend = ev_if.ev_valid & ~ev_if.ev_ready;
      hold_v    = {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code};
      if (frm_err) frm_seen++;
    end
  end

  // Monitor for the raw-byte instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (raw_if.ev_valid) begin
        if (raw_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_raw actual=%0h expected=none", raw_if.ev_code);
        end else begin
          check("raw_event", {raw_if.ev_ext, raw_if.ev_brk, raw_if.ev_code}, raw_q.pop_front());
        end
      end
      if (frm_err_r) frm_seen_r++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: what a frame should produce, decided before it is sent.
  task automatic model(input logic [7:0] b, input bit good);
    if (!good) begin
      frm_exp++;
    end else begin
      raw_q.push_back({2'b00, b});
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (ready_mode == 0 && exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({m_ext, m_brk, b});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // kind: 0 good, 1 start bit high, 2 stop bit low, 3 parity inverted
  task automatic send_byte(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    if (kind == 1) f[0] = 1'b1;
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[9] = ~f[9];
    model(b, (kind == 0) || (kind == 3 && !PAR_EN));
    send_bits(f, 11);
    cycles(6);
  endtask

  task automatic send_timeout(input int nbits);
    frm_exp++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_bits(11'h7fe, nbits);
    cycles(TMO + 20);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || raw_q.size() != 0); i++)
      @(posedge clk);
    cycles(2);
    check("drain_left", exp_q.size() + raw_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, ev_if.ev_valid, 0);
    check({tag, "_cnt"}, fifo_cnt, 0);
    check({tag, "_code"}, {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, 0);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ovf_clr = 1'b0;
    cycles(4);
    check_idle("reset");
    check("reset_ovf", {ovf, ovf_r}, 0);
    check("reset_frm_err", {frm_err, frm_err_r}, 0);
    check("reset_raw_valid", raw_if.ev_valid, 0);
    rst = 1'b0;
    cycles(4);

    // Single make code.
    send_byte(8'h1C, 0);
    wait_drain();
    check_idle("after_1c");

    // Extended release folding, then a plain make of the same code.
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    send_byte(8'h75, 0);
    wait_drain();

    // Overflow: nine events against a stalled consumer.
    ready_mode = 0;
    cycles(2);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 0);
    cycles(4);
    check("full_cnt", fifo_cnt, DEPTH);
    check("ovf_set", ovf, m_ovf);
    check("head_code", {ev_if.ev_valid, ev_if.ev_code}, {1'b1, 8'h01});
    ready_mode = 1;
    wait_drain();
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    cycles(1);
    check("ovf_cleared", ovf, 0);
    m_ovf = 1'b0;

    // Bad stop bit, then a good frame.
    send_byte(8'h33, 2);
    check("stop_err_cnt", fifo_cnt, 0);
    check("stop_err_pulse", frm_seen, frm_exp);
    send_byte(8'h34, 0);
    wait_drain();

    // Timeout mid-frame discards a pending E0 prefix too.
    send_byte(8'hE0, 0);
    send_timeout(5);
    check("timeout_pulse", frm_seen, frm_exp);
    send_byte(8'h29, 0);
    wait_drain();

    // Parity flipped on 0x1C, and a bad start bit.
    send_byte(8'h1C, 3);
    send_byte(8'h1C, 1);
    wait_drain();
    check("parity_pulse", frm_seen, frm_exp);

    // Randomised traffic with a jittery consumer.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 99);
      b = (sel < 20) ? 8'hE0 : (sel < 35) ? 8'hF0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) send_timeout($urandom_range(1, 10));
      else send_byte(b, ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3));
    end
    ready_mode = 1;
    wait_drain();
    check("random_frm_err", frm_seen, frm_exp);
    check("random_frm_err_raw", frm_seen_r, frm_exp);

    // Reset in the middle of a frame with an E0 prefix pending.
    send_byte(8'hE0, 0);
    send_bits(11'h0aa, 4);
    rst = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    cycles(3);
    check_idle("midreset");
    rst = 1'b0;
    ps2_clk = 1'b1;
    cycles(4);
    send_byte(8'h1C, 0);
    wait_drain();
    check("final_frm_err", frm_seen, frm_exp);
    check("final_ovf", {ovf, ovf_r}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
